// File: rtl/issue_scoreboard.sv
// Per-warp register scoreboard with a one-entry registered issue stage.
// Optional stall watchdog enabled by defining SCOREBOARD_TIMEOUT_EN.
module issue_scoreboard #(
  parameter int unsigned NUM_WARPS      = 4,
  parameter int unsigned NUM_REGS       = 64,
  parameter int unsigned REG_TYPES      = 4,
  parameter int unsigned RID_W          = 6,
`ifdef SCOREBOARD_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1024,
`endif
  parameter int unsigned WID_W          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ibuf_valid,
  input  logic [WID_W-1:0]              ibuf_wid,
  input  logic [RID_W-1:0]              ibuf_rd,
  input  logic [RID_W-1:0]              ibuf_rs1,
  input  logic [RID_W-1:0]              ibuf_rs2,
  input  logic [RID_W-1:0]              ibuf_rs3,
  input  logic [REG_TYPES-1:0]          ibuf_use,
  output logic                          ibuf_ready,
  output logic                          sb_valid,
  output logic [WID_W-1:0]              sb_wid,
  output logic [RID_W-1:0]              sb_rd,
  output logic [RID_W-1:0]              sb_rs1,
  output logic [RID_W-1:0]              sb_rs2,
  output logic [RID_W-1:0]              sb_rs3,
  output logic [REG_TYPES-1:0]          sb_use,
  input  logic                          sb_ready,
  input  logic                          wb_valid,
  input  logic [WID_W-1:0]              wb_wid,
  input  logic [RID_W-1:0]              wb_rd,
  output logic [REG_TYPES-1:0]          regs_busy,
`ifdef SCOREBOARD_TIMEOUT_EN
  output logic                          timeout,
  output logic [WID_W-1:0]              timeout_wid,
  output logic [REG_TYPES-1:0]          timeout_mask,
`endif
  output logic [NUM_WARPS*NUM_REGS-1:0] inuse_regs
);

  localparam int unsigned NBITS = NUM_WARPS * NUM_REGS;
  localparam int unsigned IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  function automatic logic [IDX_W-1:0] bit_idx(input logic [WID_W-1:0] wid,
                                               input logic [RID_W-1:0] rid);
    return IDX_W'(IDX_W'(wid) * IDX_W'(NUM_REGS) + IDX_W'(rid));
  endfunction

  logic [NBITS-1:0]     r_inuse;
  logic [NBITS-1:0]     w_inuse_fwd;
  logic [NBITS-1:0]     w_inuse_n;
  logic [RID_W-1:0]     w_slot_idx [REG_TYPES];
  logic [REG_TYPES-1:0] w_busy;
  logic                 w_ibuf_wid_ok;
  logic                 w_wb_hit;
  logic                 w_stage_free;
  logic                 w_accept;

  logic                 r_sb_valid;
  logic [WID_W-1:0]     r_sb_wid;
  logic [RID_W-1:0]     r_sb_rd;
  logic [RID_W-1:0]     r_sb_rs1;
  logic [RID_W-1:0]     r_sb_rs2;
  logic [RID_W-1:0]     r_sb_rs3;
  logic [REG_TYPES-1:0] r_sb_use;

  assign w_ibuf_wid_ok = 32'(ibuf_wid) < 32'(NUM_WARPS);
  assign w_wb_hit      = wb_valid && (wb_rd != '0) && (32'(wb_wid) < 32'(NUM_WARPS));

  always_comb begin
    for (int k = 0; k < REG_TYPES; k++) w_slot_idx[k] = '0;
    w_slot_idx[0] = ibuf_rd;
    w_slot_idx[1] = ibuf_rs1;
    w_slot_idx[2] = ibuf_rs2;
    w_slot_idx[3] = ibuf_rs3;
  end

  // Writeback release is applied before the hazard check so a waiter can issue the same cycle.
  always_comb begin
    w_inuse_fwd = r_inuse;
    if (w_wb_hit) w_inuse_fwd[bit_idx(wb_wid, wb_rd)] = 1'b0;
  end

  always_comb begin
    w_busy = '0;
    for (int k = 0; k < REG_TYPES; k++)
      w_busy[k] = ibuf_use[k] && (w_slot_idx[k] != '0) && w_ibuf_wid_ok &&
                  w_inuse_fwd[bit_idx(ibuf_wid, w_slot_idx[k])];
  end

  assign w_stage_free = !r_sb_valid || sb_ready;
  assign w_accept     = ibuf_valid && w_stage_free && (w_busy == '0);

  // New reservation lands after the release, so set wins on the same bit.
  always_comb begin
    w_inuse_n = w_inuse_fwd;
    if (w_accept && ibuf_use[0] && (ibuf_rd != '0) && w_ibuf_wid_ok)
      w_inuse_n[bit_idx(ibuf_wid, ibuf_rd)] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inuse    <= '0;
      r_sb_valid <= 1'b0;
      r_sb_wid   <= '0;
      r_sb_rd    <= '0;
      r_sb_rs1   <= '0;
      r_sb_rs2   <= '0;
      r_sb_rs3   <= '0;
      r_sb_use   <= '0;
    end else begin
      r_inuse <= w_inuse_n;
      if (w_accept) begin
        r_sb_valid <= 1'b1;
        r_sb_wid   <= ibuf_wid;
        r_sb_rd    <= ibuf_rd;
        r_sb_rs1   <= ibuf_rs1;
        r_sb_rs2   <= ibuf_rs2;
        r_sb_rs3   <= ibuf_rs3;
        r_sb_use   <= ibuf_use;
      end else if (sb_ready) begin
        r_sb_valid <= 1'b0;
      end
    end
  end

`ifdef SCOREBOARD_TIMEOUT_EN
  logic [31:0]          r_stall_cnt;
  logic                 r_timeout;
  logic [WID_W-1:0]     r_timeout_wid;
  logic [REG_TYPES-1:0] r_timeout_mask;
  logic                 w_stall;

  assign w_stall = ibuf_valid && (w_busy != '0);

  // Sticky watchdog: first expiry captures the blocked warp and slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt    <= '0;
      r_timeout      <= 1'b0;
      r_timeout_wid  <= '0;
      r_timeout_mask <= '0;
    end else if (w_stall) begin
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!r_timeout && ((r_stall_cnt + 32'd1) == 32'(TIMEOUT_CYCLES))) begin
        r_timeout      <= 1'b1;
        r_timeout_wid  <= ibuf_wid;
        r_timeout_mask <= w_busy;
      end
    end else if (!ibuf_valid || w_accept) begin
      r_stall_cnt <= '0;
    end
  end

  assign timeout      = r_timeout;
  assign timeout_wid  = r_timeout_wid;
  assign timeout_mask = r_timeout_mask;
`endif

  assign ibuf_ready = w_accept;
  assign regs_busy  = w_busy;
  assign inuse_regs = r_inuse;
  assign sb_valid   = r_sb_valid;
  assign sb_wid     = r_sb_wid;
  assign sb_rd      = r_sb_rd;
  assign sb_rs1     = r_sb_rs1;
  assign sb_rs2     = r_sb_rs2;
  assign sb_rs3     = r_sb_rs3;
  assign sb_use     = r_sb_use;

endmodule
